soc_freq_bank: RTL and testbench

Multi-channel frequency register bank on an Avalon-MM slave, generalising the single-word frequency output port to NUM_CH independent channels. Software writes per-channel shadow words, then commits all channels atomically with one control write so oscillators never see a half-updated chord. An optional glide engine slews each output toward its committed target by a programmable step per sample tick (portamento). It sits between the Nios II data bus and the oscillator/phase-accumulator array.

---
 rtl/soc_freq_pkg.sv | 22 ++
 rtl/soc_freq_glide.sv | 88 ++++++++
 rtl/soc_freq_bank.sv | 119 +++++++++++
 tb/tb_soc_freq_bank.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_freq_pkg.sv
// Shared definitions for the multi-channel frequency register bank:
// register offsets, CTRL bit positions and the glide direction encoding.
package soc_freq_pkg;

   localparam int CTRL_COMMIT_BIT  = 0;
   localparam int CTRL_GLIDING_BIT = 1;

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } glide_dir_e;

   function automatic int addr_ctrl(input int num_ch);
      return num_ch;
   endfunction

   function automatic int addr_step(input int num_ch);
      return num_ch + 1;
   endfunction

endpackage

// File: rtl/soc_freq_glide.sv
// One channel's TARGET/CUR slewer. With SOC_FREQ_GLIDE_EN undefined the
// channel has no target register and every commit is an immediate jump.
module soc_freq_glide
   import soc_freq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick_i,
   input  logic             commit_i,
   input  logic [WIDTH-1:0] shadow_i,
   input  logic [WIDTH-1:0] step_i,
   output logic [WIDTH-1:0] cur_o,
   output logic             gliding_o
);

   logic [WIDTH-1:0] cur_q, cur_d;

`ifdef SOC_FREQ_GLIDE_EN
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH:0]   dist;
   glide_dir_e       dir;

   always_comb begin
      dir      = DIR_HOLD;
      target_d = target_q;
      cur_d    = cur_q;
      if (target_q > cur_q) begin
         dir = DIR_UP;
      end else if (target_q < cur_q) begin
         dir = DIR_DOWN;
      end
      // Distance at WIDTH+1 bits so neither the compare nor the step can wrap.
      dist = (dir == DIR_UP) ? ({1'b0, target_q} - {1'b0, cur_q})
                             : ({1'b0, cur_q} - {1'b0, target_q});
      if (commit_i) begin
         target_d = shadow_i;
         if (step_i == '0) begin
            cur_d = shadow_i;
         end
      end else if (tick_i) begin
         if ((step_i == '0) || (dist <= {1'b0, step_i})) begin
            cur_d = target_q;
         end else if (dir == DIR_UP) begin
            cur_d = cur_q + step_i;
         end else begin
            cur_d = cur_q - step_i;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target_q <= '0;
         cur_q    <= '0;
      end else begin
         target_q <= target_d;
         cur_q    <= cur_d;
      end
   end

   assign gliding_o = (dir != DIR_HOLD);
`else
   logic unused_glide;
   assign unused_glide = ^{tick_i, step_i};

   always_comb begin
      cur_d = cur_q;
      if (commit_i) begin
         cur_d = shadow_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_q <= '0;
      end else begin
         cur_q <= cur_d;
      end
   end

   assign gliding_o = 1'b0;
`endif

   assign cur_o = cur_q;

endmodule

// File: rtl/soc_freq_bank.sv
// Avalon-MM frequency register bank: per-channel shadows committed atomically
// through CTRL, with an optional portamento engine (SOC_FREQ_GLIDE_EN).
module soc_freq_bank
   import soc_freq_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   input  logic                    sample_tick,
   output logic [NUM_CH*WIDTH-1:0] out_freq,
   output logic                    out_update
);

   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(addr_ctrl(NUM_CH));
   localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(addr_step(NUM_CH));

   logic                    wr;
   logic                    commit;
   logic [WIDTH-1:0]        shadow_q [NUM_CH];
   logic [WIDTH-1:0]        shadow_d [NUM_CH];
   logic [WIDTH-1:0]        step_val;
   logic [NUM_CH-1:0]       gliding;
   logic [NUM_CH*WIDTH-1:0] prev_freq_q;

   assign wr     = chipselect && !write_n;
   assign commit = wr && (address == A_CTRL) && writedata[CTRL_COMMIT_BIT];

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr && (address == ADDR_W'(i))) begin
            shadow_d[i] = writedata[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
      end
   end

`ifdef SOC_FREQ_GLIDE_EN
   logic [WIDTH-1:0] step_q, step_d;

   always_comb begin
      step_d = step_q;
      if (wr && (address == A_STEP)) begin
         step_d = writedata[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_q <= '0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step_val = step_q;
`else
   assign step_val = '0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      soc_freq_glide #(.WIDTH(WIDTH)) u_glide (
         .clk       (clk),
         .reset_n   (reset_n),
         .tick_i    (sample_tick),
         .commit_i  (commit),
         .shadow_i  (shadow_q[g]),
         .step_i    (step_val),
         .cur_o     (out_freq[g*WIDTH +: WIDTH]),
         .gliding_o (gliding[g])
      );
   end

   // Previous-edge copy of the outputs; any difference is a fresh update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_freq_q <= '0;
      end else begin
         prev_freq_q <= out_freq;
      end
   end

   assign out_update = (out_freq != prev_freq_q);

   always_comb begin
      readdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (address == ADDR_W'(i)) begin
            readdata = 32'(shadow_q[i]);
         end
      end
      if (address == A_CTRL) begin
         readdata[CTRL_GLIDING_BIT] = |gliding;
      end
`ifdef SOC_FREQ_GLIDE_EN
      if (address == A_STEP) begin
         readdata = 32'(step_val);
      end
`endif
   end

endmodule

// File: tb/tb_soc_freq_bank.sv
// Directed bench for soc_freq_bank (4 channels, 32-bit words); glide
// scenarios are built when SOC_FREQ_GLIDE_EN is defined.
module tb_soc_freq_bank;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic [ADDR_W-1:0]       address = '0;
   logic                    chipselect = 1'b0;
   logic                    write_n = 1'b1;
   logic [31:0]             writedata = '0;
   logic [31:0]             readdata;
   logic                    sample_tick = 1'b0;
   logic [NUM_CH*WIDTH-1:0] out_freq;
   logic                    out_update;

   int vectors = 0;
   int miscompares = 0;

   soc_freq_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .sample_tick (sample_tick),
      .out_freq    (out_freq),
      .out_update  (out_update)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ch(input int i);
      return out_freq[i*WIDTH +: WIDTH];
   endfunction

   // Drivers: inputs change on the falling edge, outputs are sampled there too.
   task automatic do_write(input int a, input logic [31:0] d, input logic tick);
      @(negedge clk);
      address     = ADDR_W'(a);
      writedata   = d;
      chipselect  = 1'b1;
      write_n     = 1'b0;
      sample_tick = tick;
      @(negedge clk);
      chipselect  = 1'b0;
      write_n     = 1'b1;
      sample_tick = 1'b0;
      #1;
   endtask

   task automatic do_read(input int a, output logic [31:0] d);
      @(negedge clk);
      address = ADDR_W'(a);
      #1;
      d = readdata;
   endtask

   task automatic do_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (out_update !== 1'b0) begin
            $display("FAIL reset_update_hold: got %b expected 0", out_update);
            miscompares++;
         end
      end
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         do_read(a, rd);
         vectors++;
         if (rd !== 32'h0) begin
            $display("FAIL reset_read[%0d]: got %h expected 0", a, rd);
            miscompares++;
         end
      end
      vectors++;
      if (out_freq !== '0 || out_update !== 1'b0) begin
         $display("FAIL reset_outputs: got %h/%b expected 0/0", out_freq, out_update);
         miscompares++;
      end
   endtask

   task automatic test_atomic_commit();
      logic [31:0] rd;
      do_write(0, 32'h1000, 1'b0);
      do_write(3, 32'h2000, 1'b0);
      vectors++;
      if (out_freq !== '0 || out_update !== 1'b0) begin
         $display("FAIL shadow_no_effect: got %h/%b expected 0/0", out_freq, out_update);
         miscompares++;
      end
      do_read(3, rd);
      vectors++;
      if (rd !== 32'h2000) begin
         $display("FAIL shadow3_read: got %h expected 00002000", rd);
         miscompares++;
      end
      do_write(4, 32'h1, 1'b0);
      vectors++;
      if (out_freq !== {32'h2000, 32'h0, 32'h0, 32'h1000} || out_update !== 1'b1) begin
         $display("FAIL commit_both: got %h/%b expected 00002000000000000000000000001000/1",
                  out_freq, out_update);
         miscompares++;
      end
      @(negedge clk);
      #1;
      vectors++;
      if (out_update !== 1'b0) begin
         $display("FAIL update_single_pulse: got %b expected 0", out_update);
         miscompares++;
      end
      do_read(4, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL ctrl_selfclear: got %h expected 0", rd);
         miscompares++;
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd;
      do_write(6, 32'hFFFF_FFFF, 1'b0);
      do_read(6, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL oor_read: got %h expected 0", rd);
         miscompares++;
      end
      do_read(0, rd);
      vectors++;
      if (rd !== 32'h1000 || ch(0) !== 32'h1000 || ch(3) !== 32'h2000) begin
         $display("FAIL oor_no_change: got %h/%h/%h expected 1000/1000/2000", rd, ch(0), ch(3));
         miscompares++;
      end
   endtask

`ifdef SOC_FREQ_GLIDE_EN
   task automatic test_glide_up();
      logic [31:0] rd;
      logic [31:0] exp_up [4];
      exp_up = '{32'h100, 32'h200, 32'h300, 32'h350};
      do_write(0, 32'h0, 1'b0);
      do_write(4, 32'h1, 1'b0);
      do_write(5, 32'h100, 1'b0);
      do_read(5, rd);
      vectors++;
      if (rd !== 32'h100) begin
         $display("FAIL step_read: got %h expected 100", rd);
         miscompares++;
      end
      do_write(0, 32'h350, 1'b0);
      do_write(4, 32'h1, 1'b0);
      do_read(4, rd);
      vectors++;
      if (ch(0) !== 32'h0 || rd !== 32'h2) begin
         $display("FAIL glide_commit_hold: got %h ctrl %h expected 0 ctrl 2", ch(0), rd);
         miscompares++;
      end
      for (int t = 0; t < 4; t++) begin
         do_tick();
         vectors++;
         if (ch(0) !== exp_up[t] || out_update !== 1'b1) begin
            $display("FAIL glide_up_tick%0d: got %h/%b expected %h/1", t + 1, ch(0), out_update, exp_up[t]);
            miscompares++;
         end
      end
      do_read(4, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL glide_done_ctrl: got %h expected 0", rd);
         miscompares++;
      end
   endtask

   task automatic test_glide_down_on_tick();
      logic [31:0] exp_dn [3];
      exp_dn = '{32'h200, 32'h100, 32'h80};
      do_write(0, 32'h300, 1'b0);
      do_write(4, 32'h1, 1'b0);
      do_tick();
      do_write(0, 32'h80, 1'b0);
      do_write(4, 32'h1, 1'b1);
      vectors++;
      if (ch(0) !== 32'h300) begin
         $display("FAIL commit_on_tick_hold: got %h expected 300", ch(0));
         miscompares++;
      end
      for (int t = 0; t < 3; t++) begin
         do_tick();
         vectors++;
         if (ch(0) !== exp_dn[t]) begin
            $display("FAIL glide_down_tick%0d: got %h expected %h", t + 1, ch(0), exp_dn[t]);
            miscompares++;
         end
      end
   endtask

   task automatic test_retarget_and_reset();
      logic [31:0] rd;
      do_write(5, 32'h80, 1'b0);
      do_write(0, 32'h500, 1'b0);
      do_write(4, 32'h1, 1'b0);
      for (int t = 0; t < 3; t++) do_tick();
      vectors++;
      if (ch(0) !== 32'h200) begin
         $display("FAIL retarget_setup: got %h expected 200", ch(0));
         miscompares++;
      end
      do_write(5, 32'h100, 1'b0);
      do_write(0, 32'h0, 1'b0);
      do_write(4, 32'h1, 1'b0);
      vectors++;
      if (ch(0) !== 32'h200) begin
         $display("FAIL retarget_no_jump: got %h expected 200", ch(0));
         miscompares++;
      end
      do_tick();
      do_read(4, rd);
      vectors++;
      if (ch(0) !== 32'h100 || rd !== 32'h2) begin
         $display("FAIL retarget_ramp: got %h ctrl %h expected 100 ctrl 2", ch(0), rd);
         miscompares++;
      end
      @(negedge clk);
      reset_n     = 1'b0;
      sample_tick = 1'b1;
      #1;
      vectors++;
      if (out_freq !== '0 || out_update !== 1'b0) begin
         $display("FAIL reset_mid_glide: got %h/%b expected 0/0", out_freq, out_update);
         miscompares++;
      end
      @(negedge clk);
      reset_n     = 1'b1;
      sample_tick = 1'b0;
      do_read(5, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL reset_step_cleared: got %h expected 0", rd);
         miscompares++;
      end
      do_tick();
      vectors++;
      if (out_freq !== '0 || out_update !== 1'b0) begin
         $display("FAIL post_reset_idle: got %h/%b expected 0/0", out_freq, out_update);
         miscompares++;
      end
   endtask
`else
   task automatic test_no_glide();
      logic [31:0] rd;
      do_write(5, 32'h100, 1'b0);
      do_read(5, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL step_absent_read: got %h expected 0", rd);
         miscompares++;
      end
      do_write(0, 32'h55, 1'b0);
      do_write(4, 32'h1, 1'b1);
      vectors++;
      if (ch(0) !== 32'h55 || ch(3) !== 32'h2000 || out_update !== 1'b1) begin
         $display("FAIL jump_commit: got %h/%h/%b expected 55/2000/1", ch(0), ch(3), out_update);
         miscompares++;
      end
      do_read(4, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL ctrl_no_gliding_bit: got %h expected 0", rd);
         miscompares++;
      end
      do_tick();
      vectors++;
      if (ch(0) !== 32'h55 || out_update !== 1'b0) begin
         $display("FAIL tick_ignored: got %h/%b expected 55/0", ch(0), out_update);
         miscompares++;
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      vectors++;
      if (out_freq !== '0 || out_update !== 1'b0) begin
         $display("FAIL reset_midway: got %h/%b expected 0/0", out_freq, out_update);
         miscompares++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      do_read(0, rd);
      vectors++;
      if (rd !== 32'h0) begin
         $display("FAIL reset_shadow_cleared: got %h expected 0", rd);
         miscompares++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_atomic_commit();
      test_out_of_range();
`ifdef SOC_FREQ_GLIDE_EN
      test_glide_up();
      test_glide_down_on_tick();
      test_retarget_and_reset();
`else
      test_no_glide();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
